// File: rtl/bus_arbiter.sv
// Two-port bus arbiter: instruction fetch (port 0) and load/store (port 1)
// share one bus master. One non-pipelined transfer at a time: an address
// phase (NONSEQ), then a data phase. The result is returned to the owner
// with a single-cycle done pulse. All outputs come straight from registers.
module bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [1:0]            write,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic                  bus_write,
    output logic [DATA_WIDTH-1:0] bus_write_data,
    output logic [1:0]            bus_trans,
    input  logic                  bus_ready,
    input  logic                  bus_response,
    input  logic [DATA_WIDTH-1:0] bus_read_data
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic       FIXED_PRIO   = (FIXED_PRIORITY != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t                state_r,          state_nxt_s;
    logic                  last_r,           last_nxt_s;
    logic                  owner_r,          owner_nxt_s;
    logic [DATA_WIDTH-1:0] wdata_r,          wdata_nxt_s;
    logic [1:0]            gnt_r,            gnt_nxt_s;
    logic [1:0]            done_r,           done_nxt_s;
    logic [DATA_WIDTH-1:0] rdata_r,          rdata_nxt_s;
    logic                  error_r,          error_nxt_s;
    logic [ADDR_WIDTH-1:0] bus_address_r,    bus_address_nxt_s;
    logic                  bus_write_r,      bus_write_nxt_s;
    logic [DATA_WIDTH-1:0] bus_write_data_r, bus_write_data_nxt_s;
    logic [1:0]            bus_trans_r,      bus_trans_nxt_s;
    logic                  winner_s;

    // Winner index: a lone requester wins; on a tie either port 1 (fixed
    // priority) or the port that was not served last (round-robin).
    function automatic logic pick_winner(input logic [1:0] req_v,
                                         input logic       last_v,
                                         input logic       fixed_v);
        logic w;
        case (req_v)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            2'b11:   w = fixed_v ? 1'b1 : ~last_v;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    // One-hot encoding of a port index.
    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Next-state and next-output computation; every register holds by default
    // and done falls back to zero so it only ever pulses for one cycle.
    always_comb begin
        state_nxt_s          = state_r;
        last_nxt_s           = last_r;
        owner_nxt_s          = owner_r;
        wdata_nxt_s          = wdata_r;
        gnt_nxt_s            = gnt_r;
        done_nxt_s           = 2'b00;
        rdata_nxt_s          = rdata_r;
        error_nxt_s          = error_r;
        bus_address_nxt_s    = bus_address_r;
        bus_write_nxt_s      = bus_write_r;
        bus_write_data_nxt_s = bus_write_data_r;
        bus_trans_nxt_s      = bus_trans_r;
        winner_s             = pick_winner(req, last_r, FIXED_PRIO);

        case (state_r)
            ST_IDLE: begin
                if ((req != 2'b00) && bus_ready) begin
                    owner_nxt_s       = winner_s;
                    gnt_nxt_s         = port_onehot(winner_s);
                    bus_address_nxt_s = winner_s ? addr1 : addr0;
                    bus_write_nxt_s   = write[winner_s];
                    wdata_nxt_s       = winner_s ? wdata1 : wdata0;
                    bus_trans_nxt_s   = TRANS_NONSEQ;
                    state_nxt_s       = ST_ADDR;
                end else begin
                    state_nxt_s       = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (bus_ready) begin
                    bus_trans_nxt_s      = TRANS_IDLE;
                    bus_write_data_nxt_s = wdata_r;
                    state_nxt_s          = ST_DATA;
                end else begin
                    state_nxt_s          = ST_ADDR;
                end
            end
            ST_DATA: begin
                // The response is only meaningful when the phase completes;
                // an ERROR seen during a wait state is ignored.
                if (bus_ready) begin
                    done_nxt_s      = port_onehot(owner_r);
                    rdata_nxt_s     = bus_read_data;
                    error_nxt_s     = bus_response;
                    gnt_nxt_s       = 2'b00;
                    last_nxt_s      = owner_r;
                    bus_write_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    state_nxt_s     = ST_DATA;
                end
            end
            default: begin
                gnt_nxt_s       = 2'b00;
                bus_write_nxt_s = 1'b0;
                bus_trans_nxt_s = TRANS_IDLE;
                state_nxt_s     = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            last_r           <= 1'b1;
            owner_r          <= 1'b0;
            wdata_r          <= {DATA_WIDTH{1'b0}};
            gnt_r            <= 2'b00;
            done_r           <= 2'b00;
            rdata_r          <= {DATA_WIDTH{1'b0}};
            error_r          <= 1'b0;
            bus_address_r    <= {ADDR_WIDTH{1'b0}};
            bus_write_r      <= 1'b0;
            bus_write_data_r <= {DATA_WIDTH{1'b0}};
            bus_trans_r      <= TRANS_IDLE;
        end else begin
            state_r          <= state_nxt_s;
            last_r           <= last_nxt_s;
            owner_r          <= owner_nxt_s;
            wdata_r          <= wdata_nxt_s;
            gnt_r            <= gnt_nxt_s;
            done_r           <= done_nxt_s;
            rdata_r          <= rdata_nxt_s;
            error_r          <= error_nxt_s;
            bus_address_r    <= bus_address_nxt_s;
            bus_write_r      <= bus_write_nxt_s;
            bus_write_data_r <= bus_write_data_nxt_s;
            bus_trans_r      <= bus_trans_nxt_s;
        end
    end

    assign gnt            = gnt_r;
    assign done           = done_r;
    assign rdata          = rdata_r;
    assign error          = error_r;
    assign bus_address    = bus_address_r;
    assign bus_write      = bus_write_r;
    assign bus_write_data = bus_write_data_r;
    assign bus_trans      = bus_trans_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin and a fixed-priority instance share the
// same stimulus; a cycle-level behavioural model per instance is compared on
// every cycle, plus directed scenarios with literal expectations.
module tb_bus_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] addr0, addr1;
    logic [1:0]  write;
    logic [31:0] wdata0, wdata1;
    logic        bus_ready;
    logic        bus_response;
    logic [31:0] bus_read_data;

    logic [1:0]  gnt_rr, done_rr, trans_rr;
    logic [31:0] rdata_rr, addr_rr, wd_rr;
    logic        err_rr, wr_rr;
    logic [1:0]  gnt_fp, done_fp, trans_fp;
    logic [31:0] rdata_fp, addr_fp, wd_fp;
    logic        err_fp, wr_fp;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit cmp_en = 1'b0;

    bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(0)) dut_rr (
        .clock(clock), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1),
        .write(write), .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt_rr),
        .done(done_rr), .rdata(rdata_rr), .error(err_rr), .bus_address(addr_rr),
        .bus_write(wr_rr), .bus_write_data(wd_rr), .bus_trans(trans_rr),
        .bus_ready(bus_ready), .bus_response(bus_response),
        .bus_read_data(bus_read_data));

    bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1)) dut_fp (
        .clock(clock), .reset(reset), .req(req), .addr0(addr0), .addr1(addr1),
        .write(write), .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt_fp),
        .done(done_fp), .rdata(rdata_fp), .error(err_fp), .bus_address(addr_fp),
        .bus_write(wr_fp), .bus_write_data(wd_fp), .bus_trans(trans_fp),
        .bus_ready(bus_ready), .bus_response(bus_response),
        .bus_read_data(bus_read_data));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected externally visible behaviour; phase 0 = no transfer,
    // 1 = address phase, 2 = data phase.
    typedef struct {
        int          phase;
        int          owner;
        int          last;
        logic [31:0] lat;
        logic [1:0]  gnt;
        logic [1:0]  done;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } model_t;

    model_t m_rr, m_fp;

    function automatic model_t model_step(model_t m, bit fp);
        model_t n;
        int w;
        n = m;
        if (reset) begin
            n.phase = 0; n.owner = 0; n.last = 1; n.lat = 32'h0;
            n.gnt = 2'b00; n.done = 2'b00; n.rdata = 32'h0; n.err = 1'b0;
            n.addr = 32'h0; n.wr = 1'b0; n.wdata = 32'h0; n.trans = 2'b00;
            return n;
        end
        n.done = 2'b00;
        if (m.phase == 0) begin
            if (req != 2'b00 && bus_ready) begin
                if (req == 2'b01)      w = 0;
                else if (req == 2'b10) w = 1;
                else                   w = fp ? 1 : 1 - m.last;
                n.owner = w;
                n.gnt   = (w == 1) ? 2'b10 : 2'b01;
                n.addr  = (w == 1) ? addr1 : addr0;
                n.wr    = write[w];
                n.lat   = (w == 1) ? wdata1 : wdata0;
                n.trans = 2'b10;
                n.phase = 1;
            end
        end else if (m.phase == 1) begin
            if (bus_ready) begin
                n.trans = 2'b00;
                n.wdata = m.lat;
                n.phase = 2;
            end
        end else begin
            if (bus_ready) begin
                n.done  = (m.owner == 1) ? 2'b10 : 2'b01;
                n.rdata = bus_read_data;
                n.err   = bus_response;
                n.gnt   = 2'b00;
                n.last  = m.owner;
                n.wr    = 1'b0;
                n.phase = 0;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic cmp_dut(input string tag, input model_t m,
                           input logic [1:0] g, input logic [1:0] d, input logic [1:0] t,
                           input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input logic e);
        check({tag, ".gnt"},       {30'h0, g}, {30'h0, m.gnt});
        check({tag, ".done"},      {30'h0, d}, {30'h0, m.done});
        check({tag, ".bus_trans"}, {30'h0, t}, {30'h0, m.trans});
        check({tag, ".bus_write"}, {31'h0, w}, {31'h0, m.wr});
        if (m.gnt != 2'b00) check({tag, ".bus_address"}, a, m.addr);
        if (m.phase == 2 && m.wr) check({tag, ".bus_write_data"}, wd, m.wdata);
        if (m.done != 2'b00) begin
            check({tag, ".rdata"}, rd, m.rdata);
            check({tag, ".error"}, {31'h0, e}, {31'h0, m.err});
        end
    endtask

    // Model advances on the same edge the DUTs sample their inputs.
    always @(posedge clock) begin
        m_rr = model_step(m_rr, 1'b0);
        m_fp = model_step(m_fp, 1'b1);
    end

    // Compare both instances against their models away from the active edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            cmp_dut("rr", m_rr, gnt_rr, done_rr, trans_rr, wr_rr, addr_rr, wd_rr, rdata_rr, err_rr);
            cmp_dut("fp", m_fp, gnt_fp, done_fp, trans_fp, wr_fp, addr_fp, wd_fp, rdata_fp, err_fp);
        end
    end

    logic [1:0] grants[4];
    int         ngrant;
    int         fp_port0;
    logic [1:0] prev_g;

    initial begin
        reset = 1'b1; req = 2'b00; addr0 = 32'h0; addr1 = 32'h0; write = 2'b00;
        wdata0 = 32'h0; wdata1 = 32'h0; bus_ready = 1'b1; bus_response = 1'b0;
        bus_read_data = 32'h0;
        repeat (2) @(negedge clock);
        cmp_en = 1'b1;
        check("reset.gnt",   {30'h0, gnt_rr}, 32'h0);
        check("reset.done",  {30'h0, done_rr}, 32'h0);
        check("reset.rdata", rdata_rr, 32'h0);
        check("reset.error", {31'h0, err_rr}, 32'h0);
        check("reset.addr",  addr_rr, 32'h0);
        check("reset.write", {31'h0, wr_rr}, 32'h0);
        check("reset.wdata", wd_rr, 32'h0);
        check("reset.trans", {30'h0, trans_rr}, 32'h0);
        reset = 1'b0;

        // Single read from port 0; req dropped once granted.
        req = 2'b01; addr0 = 32'h100; write = 2'b00; bus_read_data = 32'hDEADBEEF;
        @(negedge clock);
        check("t1.trans_nonseq", {30'h0, trans_rr}, 32'h2);
        check("t1.addr", addr_rr, 32'h100);
        check("t1.gnt", {30'h0, gnt_rr}, 32'h1);
        req = 2'b00;
        @(negedge clock);
        check("t1.trans_idle", {30'h0, trans_rr}, 32'h0);
        check("t1.no_done_yet", {30'h0, done_rr}, 32'h0);
        @(negedge clock);
        check("t1.done", {30'h0, done_rr}, 32'h1);
        check("t1.rdata", rdata_rr, 32'hDEADBEEF);
        check("t1.error", {31'h0, err_rr}, 32'h0);
        @(negedge clock);
        check("t1.done_pulse", {30'h0, done_rr}, 32'h0);

        // Port 1 write with two data-phase wait states.
        req = 2'b10; addr1 = 32'h2000; write = 2'b10; wdata1 = 32'h55AA55AA;
        @(negedge clock);
        check("t4.gnt", {30'h0, gnt_rr}, 32'h2);
        check("t4.bus_write", {31'h0, wr_rr}, 32'h1);
        check("t4.addr", addr_rr, 32'h2000);
        req = 2'b00;
        @(negedge clock);
        check("t4.wdata", wd_rr, 32'h55AA55AA);
        bus_ready = 1'b0;
        @(negedge clock);
        check("t4.wait1_done", {30'h0, done_rr}, 32'h0);
        check("t4.wait1_wdata", wd_rr, 32'h55AA55AA);
        @(negedge clock);
        check("t4.wait2_write", {31'h0, wr_rr}, 32'h1);
        bus_ready = 1'b1;
        @(negedge clock);
        check("t4.done", {30'h0, done_rr}, 32'h2);
        write = 2'b00;

        // Two-cycle error response, then a normal read from port 1.
        req = 2'b01; addr0 = 32'h300;
        @(negedge clock);
        req = 2'b00;
        @(negedge clock);
        bus_ready = 1'b0; bus_response = 1'b1;
        @(negedge clock);
        check("t5.err_wait_no_done", {30'h0, done_rr}, 32'h0);
        bus_ready = 1'b1;
        @(negedge clock);
        check("t5.done", {30'h0, done_rr}, 32'h1);
        check("t5.error", {31'h0, err_rr}, 32'h1);
        bus_response = 1'b0; req = 2'b10; addr1 = 32'h400; bus_read_data = 32'h12345678;
        @(negedge clock);
        check("t5.next_gnt", {30'h0, gnt_rr}, 32'h2);
        req = 2'b00;
        repeat (2) @(negedge clock);
        check("t5.next_done", {30'h0, done_rr}, 32'h2);
        check("t5.next_error", {31'h0, err_rr}, 32'h0);
        check("t5.next_rdata", rdata_rr, 32'h12345678);

        // Reset while waiting in the data phase.
        req = 2'b01;
        repeat (2) @(negedge clock);
        bus_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6.trans", {30'h0, trans_rr}, 32'h0);
        check("t6.gnt", {30'h0, gnt_rr}, 32'h0);
        check("t6.done", {30'h0, done_rr}, 32'h0);

        // Continuous contention from reset release.
        reset = 1'b0; req = 2'b11; bus_ready = 1'b1; write = 2'b00;
        ngrant = 0; fp_port0 = 0; prev_g = 2'b00;
        for (int c = 0; c < 60 && ngrant < 4; c++) begin
            @(negedge clock);
            if (gnt_rr != 2'b00 && prev_g == 2'b00) begin
                grants[ngrant] = gnt_rr;
                ngrant++;
            end
            prev_g = gnt_rr;
            if (gnt_fp == 2'b01 || done_fp == 2'b01) fp_port0++;
        end
        check("t2.grant_count", ngrant, 32'd4);
        for (int i = 0; i < ngrant; i++)
            check($sformatf("t2.grant%0d", i), {30'h0, grants[i]}, (i % 2 == 0) ? 32'h1 : 32'h2);
        check("t3.fp_port0_starved", fp_port0, 32'd0);

        // Randomized traffic with occasional resets.
        req = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            reset         = ($urandom_range(0, 199) == 0);
            bus_ready     = ($urandom_range(0, 3) != 0);
            bus_response  = 1'($urandom_range(0, 1));
            bus_read_data = $urandom;
            if (!req[0]) begin
                if ($urandom_range(0, 2) == 0) begin
                    req[0] = 1'b1; addr0 = $urandom;
                    write[0] = 1'($urandom_range(0, 1)); wdata0 = $urandom;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                req[0] = 1'b0;
            end
            if (!req[1]) begin
                if ($urandom_range(0, 2) == 0) begin
                    req[1] = 1'b1; addr1 = $urandom;
                    write[1] = 1'($urandom_range(0, 1)); wdata1 = $urandom;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                req[1] = 1'b0;
            end
        end
        @(negedge clock);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
